// File: rtl/axi_enhanced_tx_straddler_pkg.sv
// Shared encodings for the 128-bit TRN TX straddler: FSM states, QW slice
// bounds and the trem helper used by both the datapath and the FSM.
package axi_enhanced_tx_straddler_pkg;

  typedef enum logic [1:0] {
    ST_PASS  = 2'b00,
    ST_TAIL  = 2'b01,
    ST_SHIFT = 2'b10
  } state_t;

  localparam int QW_HI_MSB = 127;
  localparam int QW_HI_LSB = 64;
  localparam int QW_LO_MSB = 63;
  localparam int QW_LO_LSB = 0;

  localparam logic [1:0] REM_DW1 = 2'd1;

  // True when the last valid DW lies in the upper QW ([127:64]).
  function automatic logic ends_in_hi(input logic [1:0] rem);
    return rem <= REM_DW1;
  endfunction

endpackage

// File: rtl/axi_enhanced_tx_straddler.sv
// Re-packs QW-aligned TRN TX TLPs onto a straddle-capable 128-bit link so a
// TLP may start in [63:0] right after another TLP ends in [127:64].
module axi_enhanced_tx_straddler
  import axi_enhanced_tx_straddler_pkg::*;
#(
  parameter int C_DATA_WIDTH = 128,
  parameter int TCQ          = 1
) (
  input  logic                    com_iclk,
  input  logic                    com_sysrst,
  input  logic                    cfg_straddle_en,
  input  logic [C_DATA_WIDTH-1:0] trn_td,
  input  logic                    trn_tsof,
  input  logic                    trn_teof,
  input  logic                    trn_tsrc_rdy,
  output logic                    trn_tdst_rdy_o,
  input  logic                    trn_tsrc_dsc,
  input  logic [1:0]              trn_trem,
  input  logic                    trn_terrfwd,
  output logic [C_DATA_WIDTH-1:0] trn_td_o,
  output logic                    trn_tsof_o,
  output logic                    trn_tsof_pos_o,
  output logic                    trn_teof_o,
  output logic [1:0]              trn_trem_o,
  output logic                    trn_tsrc_rdy_o,
  input  logic                    trn_tdst_rdy,
  output logic                    trn_tsrc_dsc_o,
  output logic                    trn_terrfwd_o
);

  if (TCQ < 0) begin : g_bad_tcq
    $error("TCQ must be non-negative");
  end

  if (C_DATA_WIDTH == 128) begin : g_straddle
    state_t      state, state_nxt;
    logic [63:0] hold_qw, hold_qw_nxt;
    logic        hold_rem, hold_rem_nxt;
    logic        hold_err, hold_err_nxt;
    logic        hold_sof, hold_sof_nxt;
    logic        in_xfer, out_xfer, tail_straddle;

    assign in_xfer  = trn_tsrc_rdy && trn_tdst_rdy_o;
    assign out_xfer = trn_tsrc_rdy_o && trn_tdst_rdy;

    // Discontinue drops any held QW; otherwise state moves only on a transfer.
    always_ff @(posedge com_iclk) begin
      if (com_sysrst || (trn_tsrc_dsc && trn_tdst_rdy)) begin
        state    <= ST_PASS;
        hold_qw  <= '0;
        hold_rem <= 1'b0;
        hold_err <= 1'b0;
        hold_sof <= 1'b0;
      end else if (in_xfer || out_xfer) begin
        state    <= state_nxt;
        hold_qw  <= hold_qw_nxt;
        hold_rem <= hold_rem_nxt;
        hold_err <= hold_err_nxt;
        hold_sof <= hold_sof_nxt;
      end
    end

    always_comb begin
      state_nxt      = state;
      hold_qw_nxt    = hold_qw;
      hold_rem_nxt   = hold_rem;
      hold_err_nxt   = hold_err;
      hold_sof_nxt   = hold_sof;
      tail_straddle  = 1'b0;
      trn_tdst_rdy_o = trn_tdst_rdy;
      trn_tsrc_rdy_o = trn_tsrc_rdy;
      trn_td_o       = trn_td;
      trn_tsof_o     = trn_tsof;
      trn_tsof_pos_o = 1'b1;
      trn_teof_o     = trn_teof;
      trn_trem_o     = trn_trem;
      trn_terrfwd_o  = trn_terrfwd;
      trn_tsrc_dsc_o = trn_tsrc_dsc;

      case (state)
        ST_PASS: begin
          if (cfg_straddle_en && trn_tsrc_rdy && trn_teof && ends_in_hi(trn_trem) &&
              !trn_tsrc_dsc) begin
            trn_tsrc_rdy_o = 1'b0;
            hold_qw_nxt    = trn_td[QW_HI_MSB:QW_HI_LSB];
            hold_rem_nxt   = trn_trem[0];
            hold_err_nxt   = trn_terrfwd;
            hold_sof_nxt   = trn_tsof;
            state_nxt      = ST_TAIL;
          end
        end
        ST_TAIL: begin
          // A held tail that also carries its own SOF cannot share the beat
          // with a second SOF, so it is always emitted alone.
          tail_straddle  = trn_tsrc_rdy && trn_tsof && !hold_sof &&
                           !(trn_teof && ends_in_hi(trn_trem));
          trn_tsrc_rdy_o = 1'b1;
          trn_teof_o     = 1'b1;
          trn_trem_o     = {1'b0, hold_rem};
          trn_terrfwd_o  = hold_err;
          if (tail_straddle) begin
            trn_td_o       = {hold_qw, trn_td[QW_HI_MSB:QW_HI_LSB]};
            trn_tsof_o     = 1'b1;
            trn_tsof_pos_o = 1'b0;
            hold_qw_nxt    = trn_td[QW_LO_MSB:QW_LO_LSB];
            hold_sof_nxt   = 1'b0;
            if (trn_teof) begin
              hold_rem_nxt = trn_trem[0];
              hold_err_nxt = trn_terrfwd;
            end else begin
              state_nxt = ST_SHIFT;
            end
          end else begin
            trn_tdst_rdy_o = 1'b0;
            trn_td_o       = {hold_qw, 64'b0};
            trn_tsof_o     = hold_sof;
            hold_qw_nxt    = '0;
            hold_rem_nxt   = 1'b0;
            hold_err_nxt   = 1'b0;
            hold_sof_nxt   = 1'b0;
            state_nxt      = ST_PASS;
          end
        end
        ST_SHIFT: begin
          trn_td_o    = {hold_qw, trn_td[QW_HI_MSB:QW_HI_LSB]};
          trn_tsof_o  = 1'b0;
          hold_qw_nxt = trn_td[QW_LO_MSB:QW_LO_LSB];
          if (trn_teof && ends_in_hi(trn_trem)) begin
            trn_trem_o = {1'b1, trn_trem[0]};
            state_nxt  = ST_PASS;
          end else begin
            trn_teof_o    = 1'b0;
            trn_trem_o    = 2'd0;
            trn_terrfwd_o = 1'b0;
            if (trn_teof) begin
              hold_rem_nxt = trn_trem[0];
              hold_err_nxt = trn_terrfwd;
              state_nxt    = ST_TAIL;
            end
          end
        end
        default: state_nxt = ST_PASS;
      endcase

      if (com_sysrst) begin
        trn_tdst_rdy_o = 1'b0;
        trn_tsrc_rdy_o = 1'b0;
        trn_td_o       = '0;
        trn_tsof_o     = 1'b0;
        trn_tsof_pos_o = 1'b0;
        trn_teof_o     = 1'b0;
        trn_trem_o     = 2'd0;
        trn_terrfwd_o  = 1'b0;
        trn_tsrc_dsc_o = 1'b0;
      end
    end
  end else begin : g_pass
    assign trn_tdst_rdy_o = trn_tdst_rdy;
    assign trn_tsrc_rdy_o = trn_tsrc_rdy;
    assign trn_td_o       = trn_td;
    assign trn_tsof_o     = trn_tsof;
    assign trn_tsof_pos_o = 1'b1;
    assign trn_teof_o     = trn_teof;
    assign trn_trem_o     = trn_trem;
    assign trn_terrfwd_o  = trn_terrfwd;
    assign trn_tsrc_dsc_o = trn_tsrc_dsc;
  end

endmodule
